// File: rtl/canny_edge_packer.sv
// Binarises the canny edge stream, packs 8 pixels per byte (LSB first), tags bytes with
// frame/line markers, counts edge pixels per frame and buffers bytes in a dropping FWFT FIFO.
module canny_edge_packer #(
    parameter int IMG_W      = 632,
    parameter int IMG_H      = 504,
    parameter int DATA_W     = 16,
    parameter int THRESH     = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_byte,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_eof,
    output logic [18:0]       edge_count,
    output logic              frame_done,
    output logic              overflow
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 11;

    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

    // Pixel-path state
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [6:0]    r_sreg;
    logic [18:0]   r_edge_count;
    logic          r_frame_done;

    // FIFO state
    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic          r_overflow;

    logic          w_bit;
    logic          w_last_col;
    logic          w_last_row;
    logic          w_first_px;
    logic          w_grp_end;
    logic          w_push;
    logic          w_sof;
    logic          w_eol;
    logic          w_eof;
    logic [EW-1:0] w_entry;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_wr;
    logic [EW-1:0] w_head;

    assign w_bit      = (in_data > DATA_W'(THRESH));
    assign w_last_col = (r_col == LAST_COL);
    assign w_last_row = (r_row == LAST_ROW);
    assign w_first_px = (r_col == '0) && (r_row == '0);
    assign w_grp_end  = &r_col[2:0];
    assign w_push     = in_valid && w_grp_end;

    assign w_sof   = (r_row == '0) && (r_col == CW'(7));
    assign w_eol   = w_last_col;
    assign w_eof   = w_last_col && w_last_row;
    // The 8th pixel's bit goes straight into the entry; the first seven come from the shift reg
    assign w_entry = {w_bit, r_sreg, w_sof, w_eol, w_eof};

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = !w_empty && out_ready;
    assign w_wr    = w_push && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col        <= '0;
            r_row        <= '0;
            r_sreg       <= '0;
            r_edge_count <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= in_valid && w_last_col && w_last_row;
            if (in_valid) begin
                for (int unsigned i = 0; i < 7; i++) begin
                    if (r_col[2:0] == 3'(i)) begin
                        r_sreg[i] <= w_bit;
                    end
                end
                if (w_first_px) begin
                    r_edge_count <= 19'(w_bit);
                end else begin
                    r_edge_count <= r_edge_count + 19'(w_bit);
                end
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= w_last_row ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_wr) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the output mux masks it while the FIFO is empty
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr[AW-1:0]] <= w_entry;
        end
    end

    assign w_head    = r_mem[r_rptr[AW-1:0]];
    assign out_valid = !w_empty;
    assign {out_byte, out_sof, out_eol, out_eof} = out_valid ? w_head : '0;

    assign edge_count = r_edge_count;
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_canny_edge_packer.sv
// Directed + random bench for canny_edge_packer on a reduced 16x4 frame, two thresholds
// (0 and 100) sharing one stimulus, checked against a queue-based reference model.
module tb_canny_edge_packer;

    localparam int W     = 16;
    localparam int H     = 4;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        out_ready = 1'b0;

    logic        a_valid, a_sof, a_eol, a_eof, a_fd, a_ovf;
    logic [7:0]  a_byte;
    logic [18:0] a_cnt;
    logic        b_valid, b_sof, b_eol, b_eof, b_fd, b_ovf;
    logic [7:0]  b_byte;
    logic [18:0] b_cnt;

    canny_edge_packer #(.IMG_W(W), .IMG_H(H), .DATA_W(16), .THRESH(0), .FIFO_DEPTH(DEPTH)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .out_valid(a_valid), .out_ready(out_ready), .out_byte(a_byte),
        .out_sof(a_sof), .out_eol(a_eol), .out_eof(a_eof),
        .edge_count(a_cnt), .frame_done(a_fd), .overflow(a_ovf)
    );

    canny_edge_packer #(.IMG_W(W), .IMG_H(H), .DATA_W(16), .THRESH(100), .FIFO_DEPTH(DEPTH)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .out_valid(b_valid), .out_ready(out_ready), .out_byte(b_byte),
        .out_sof(b_sof), .out_eol(b_eol), .out_eof(b_eof),
        .edge_count(b_cnt), .frame_done(b_fd), .overflow(b_ovf)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    logic [10:0] qa[$];
    logic [10:0] qb[$];
    int          idx;
    int          cnt_a, cnt_b;
    logic [7:0]  acc_a, acc_b;
    bit          ovf;
    bit          exp_fd;

    // Stream statistics gathered from observed transfers
    bit cnt_on = 0;
    int n_bytes, n_eol, n_eof, n_nonff, n_fd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        idx    = 0;
        cnt_a  = 0;
        cnt_b  = 0;
        acc_a  = '0;
        acc_b  = '0;
        ovf    = 0;
        exp_fd = 0;
    endtask

    task automatic clear_stats();
        n_bytes = 0; n_eol = 0; n_eof = 0; n_nonff = 0; n_fd = 0;
    endtask

    task automatic model(input bit v, input logic [15:0] d, input bit rdy);
        bit pop, full, push, ba, bb;
        int col, row;
        logic [10:0] ea, eb;
        pop    = (qa.size() != 0) && rdy;
        full   = (qa.size() == DEPTH);
        push   = 0;
        exp_fd = 0;
        ea     = '0;
        eb     = '0;
        if (v) begin
            ba  = (d > 0);
            bb  = (d > 100);
            col = idx % W;
            row = idx / W;
            cnt_a = (idx == 0) ? int'(ba) : cnt_a + int'(ba);
            cnt_b = (idx == 0) ? int'(bb) : cnt_b + int'(bb);
            if (col % 8 == 0) begin
                acc_a = '0;
                acc_b = '0;
            end
            acc_a[col % 8] = ba;
            acc_b[col % 8] = bb;
            if (col % 8 == 7) begin
                push = 1;
                ea = {acc_a, (row == 0 && col == 7), (col == W-1), (col == W-1 && row == H-1)};
                eb = {acc_b, (row == 0 && col == 7), (col == W-1), (col == W-1 && row == H-1)};
            end
            exp_fd = (idx == W*H - 1);
            idx = (idx + 1) % (W*H);
        end
        if (pop) begin
            void'(qa.pop_front());
            void'(qb.pop_front());
        end
        if (push) begin
            if (full && !pop) begin
                ovf = 1;
            end else begin
                qa.push_back(ea);
                qb.push_back(eb);
            end
        end
    endtask

    task automatic check_all();
        chk("valid_a", 32'(a_valid), 32'(qa.size() != 0));
        chk("valid_b", 32'(b_valid), 32'(qb.size() != 0));
        if (qa.size() != 0) begin
            chk("entry_a", 32'({a_byte, a_sof, a_eol, a_eof}), 32'(qa[0]));
            chk("entry_b", 32'({b_byte, b_sof, b_eol, b_eof}), 32'(qb[0]));
        end else begin
            chk("idle_a", 32'({a_byte, a_sof, a_eol, a_eof}), 32'd0);
        end
        chk("count_a", 32'(a_cnt), 32'(cnt_a));
        chk("count_b", 32'(b_cnt), 32'(cnt_b));
        chk("fdone_a", 32'(a_fd), 32'(exp_fd));
        chk("fdone_b", 32'(b_fd), 32'(exp_fd));
        chk("ovf_a", 32'(a_ovf), 32'(ovf));
        chk("ovf_b", 32'(b_ovf), 32'(ovf));
    endtask

    task automatic step(input bit v, input logic [15:0] d, input bit rdy);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        if (cnt_on && a_valid && rdy) begin
            n_bytes++;
            n_eol   += int'(a_eol);
            n_eof   += int'(a_eof);
            n_nonff += int'(a_byte != 8'hFF);
        end
        @(posedge clk);
        model(v, d, rdy);
        #1;
        if (cnt_on) n_fd += int'(a_fd);
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid  = 0;
        out_ready = 0;
        rst_n     = 0;
        #1;
        chk("rst_out_a", 32'({a_valid, a_byte, a_sof, a_eol, a_eof, a_fd, a_ovf}), 32'd0);
        chk("rst_cnt_a", 32'(a_cnt), 32'd0);
        chk("rst_out_b", 32'({b_valid, b_byte, b_cnt, b_fd, b_ovf}), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    logic [15:0] t2_px [8];
    int sent;

    initial begin
        t2_px = '{16'd0, 16'd5, 16'd0, 16'd0, 16'd9, 16'd0, 16'd0, 16'd1};
        model_reset();
        clear_stats();

        // Power-on reset state
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1;

        // Packing: first group 0,5,0,0,9,0,0,1 -> 0x92 with sof, one cycle after 8th pixel
        for (int i = 0; i < 8; i++) step(1, t2_px[i], 1);
        chk("t2_byte", 32'(a_byte), 32'h92);
        chk("t2_sof", 32'(a_sof), 32'd1);
        chk("t2_valid", 32'(a_valid), 32'd1);

        // Reset mid-stream, then the next pixel is (0,0)
        for (int i = 0; i < 5; i++) step(1, 16'($urandom_range(0, 200)), 1);
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 16'd3, 1);
        chk("t1_sof", 32'(a_sof), 32'd1);
        chk("t1_byte", 32'(a_byte), 32'hFF);

        // Full frame of ones
        do_reset();
        clear_stats();
        cnt_on = 1;
        for (int i = 0; i < W*H; i++) step(1, 16'd1, 1);
        for (int i = 0; i < 4; i++) step(0, 16'd0, 1);
        cnt_on = 0;
        chk("t3_bytes", 32'(n_bytes), 32'(W*H/8));
        chk("t3_eol", 32'(n_eol), 32'(H));
        chk("t3_eof", 32'(n_eof), 32'd1);
        chk("t3_nonff", 32'(n_nonff), 32'd0);
        chk("t3_fdone", 32'(n_fd), 32'd1);
        chk("t3_count", 32'(a_cnt), 32'(W*H));

        // All-zero frame, then a threshold frame starting 100,101
        for (int i = 0; i < W*H; i++) step(1, 16'd0, 1);
        step(0, 16'd0, 1);
        chk("t4_zero_cnt", 32'(a_cnt), 32'd0);
        step(1, 16'd100, 1);
        step(1, 16'd101, 1);
        chk("t4_cnt_b", 32'(b_cnt), 32'd1);
        chk("t4_cnt_a", 32'(a_cnt), 32'd2);
        for (int i = 0; i < 5; i++) step(1, 16'd0, 1);
        step(1, 16'd200, 1);
        chk("t4_byte_b", 32'(b_byte), 32'h82);
        chk("t4_byte_a", 32'(a_byte), 32'h83);
        for (int i = 8; i < W*H; i++) step(1, 16'($urandom_range(0, 200)), $urandom_range(0, 1) == 1);
        for (int i = 0; i < 20; i++) step(0, 16'd0, 1);

        // Backpressure: 17 bytes into a 16-deep FIFO, then drain
        do_reset();
        for (int i = 0; i < 16*8; i++) step(1, 16'($urandom_range(0, 200)), 0);
        chk("t5_no_ovf_yet", 32'(a_ovf), 32'd0);
        for (int i = 0; i < 8; i++) step(1, 16'($urandom_range(0, 200)), 0);
        chk("t5_ovf", 32'(a_ovf), 32'd1);
        clear_stats();
        cnt_on = 1;
        for (int i = 0; i < 24; i++) step(0, 16'd0, 1);
        cnt_on = 0;
        chk("t5_drained", 32'(n_bytes), 32'd16);
        chk("t5_empty", 32'(a_valid), 32'd0);
        do_reset();
        chk("t5_ovf_cleared", 32'(a_ovf), 32'd0);

        // Random valid gaps and backpressure: one frame of ones, then random data
        clear_stats();
        cnt_on = 1;
        sent = 0;
        while (sent < W*H) begin
            if ($urandom_range(0, 9) < 3) begin
                step(1, 16'd1, $urandom_range(0, 1) == 1);
                sent++;
            end else begin
                step(0, 16'($urandom), $urandom_range(0, 1) == 1);
            end
        end
        for (int i = 0; i < 24; i++) step(0, 16'd0, 1);
        cnt_on = 0;
        chk("t6_bytes", 32'(n_bytes), 32'(W*H/8));
        chk("t6_eol", 32'(n_eol), 32'(H));
        chk("t6_eof", 32'(n_eof), 32'd1);
        chk("t6_nonff", 32'(n_nonff), 32'd0);
        chk("t6_fdone", 32'(n_fd), 32'd1);
        chk("t6_count", 32'(a_cnt), 32'(W*H));
        sent = 0;
        while (sent < 2*W*H) begin
            if ($urandom_range(0, 9) < 3) begin
                step(1, 16'($urandom_range(0, 200)), $urandom_range(0, 1) == 1);
                sent++;
            end else begin
                step(0, 16'($urandom), $urandom_range(0, 1) == 1);
            end
        end
        for (int i = 0; i < 24; i++) step(0, 16'd0, 1);
        chk("t6_final_empty", 32'(a_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
